// File: rtl/crossbar_pipe_pkg.sv
// Shared types and helpers for the crossbar_pipe switch: flit control-bit
// positions, output-port FSM state encoding and compressed-grant indexing.
package crossbar_pipe_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } port_state_e;

    function automatic int hdr_pos(input int fw);
        return fw - 1;
    endfunction

    function automatic int tail_pos(input int fw);
        return fw - 2;
    endfunction

    // Without self-loops an input's grant vector skips its own output, so
    // outputs above the input index shift down by one bit.
    function automatic int grant_idx(input int out_idx, input int in_idx, input bit self_loop);
        if (self_loop || out_idx < in_idx)
            return out_idx;
        return out_idx - 1;
    endfunction

endpackage

// File: rtl/crossbar_out_port.sv
// One crossbar output: request arbitration, packet lock FSM, flit mux and
// output stage. Statistics counters exist only with CROSSBAR_PIPE_STAT_EN.
module crossbar_out_port
    import crossbar_pipe_pkg::*;
#(
    parameter int P       = 5,
    parameter int Fw      = 36,
    parameter int OUT_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [P-1:0]  req,
    input  logic [P*Fw-1:0] flit_in_all,
    output logic [Fw-1:0] flit_out,
    output logic          flit_out_wr,
    output logic          lock_busy,
    output logic          conflict_err
`ifdef CROSSBAR_PIPE_STAT_EN
    ,
    output logic [31:0]   stat_flit_cnt,
    output logic [31:0]   stat_pkt_cnt
`endif
);

    localparam int HDR  = hdr_pos(Fw);
    localparam int TAIL = tail_pos(Fw);

    port_state_e   state;
    logic [P-1:0]  src;
    logic [P-1:0]  sel;
    logic          fwd;
    logic          conflict_now;
    logic [Fw-1:0] flit_sel;

    // A locked output listens only to its owner; an idle one takes the lowest index.
    always_comb begin
        sel          = '0;
        conflict_now = 1'b0;
        if (state == ST_LOCKED) begin
            sel          = req & src;
            conflict_now = |(req & ~src);
        end else begin
            sel          = req & (~req + P'(1));
            conflict_now = |(req & (req - P'(1)));
        end
    end

    assign fwd = |sel;

    always_comb begin
        flit_sel = '0;
        for (int i = 0; i < P; i++)
            if (sel[i])
                flit_sel = flit_sel | flit_in_all[i*Fw +: Fw];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            src          <= '0;
            conflict_err <= 1'b0;
        end else begin
            if (conflict_now)
                conflict_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fwd && flit_sel[HDR] && !flit_sel[TAIL]) begin
                        state <= ST_LOCKED;
                        src   <= sel;
                    end
                end
                ST_LOCKED: begin
                    if (fwd && flit_sel[TAIL]) begin
                        state <= ST_IDLE;
                        src   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    src   <= '0;
                end
            endcase
        end
    end

    assign lock_busy = (state == ST_LOCKED);

    // Stage p0 -> p1: optional output register
    if (OUT_REG != 0) begin : g_reg
        logic [Fw-1:0] flit_p1;
        logic          vld_p1;
        always_ff @(posedge clk) begin
            if (reset) begin
                flit_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= fwd;
                if (fwd)
                    flit_p1 <= flit_sel;
            end
        end
        assign flit_out    = flit_p1;
        assign flit_out_wr = vld_p1;
    end else begin : g_comb
        logic vld_p0;
        assign vld_p0      = fwd & ~reset;
        assign flit_out    = vld_p0 ? flit_sel : '0;
        assign flit_out_wr = vld_p0;
    end

`ifdef CROSSBAR_PIPE_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flit_cnt <= '0;
            stat_pkt_cnt  <= '0;
        end else if (fwd) begin
            if (stat_flit_cnt != 32'hFFFF_FFFF)
                stat_flit_cnt <= stat_flit_cnt + 32'd1;
            if (flit_sel[TAIL] && stat_pkt_cnt != 32'hFFFF_FFFF)
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: rtl/crossbar_pipe.sv
// P-port NoC crossbar with per-output packet locking and sticky conflict flags.
// Optional per-output flit/packet statistics under CROSSBAR_PIPE_STAT_EN.
module crossbar_pipe
    import crossbar_pipe_pkg::*;
#(
    parameter  int NOC_ID       = 0,
    parameter  int P            = 5,
    parameter  int Fw           = 36,
    parameter  int SELF_LOOP_EN = 0,
    parameter  int OUT_REG      = 1,
    localparam int P_1          = (SELF_LOOP_EN != 0) ? P : P - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [P*P_1-1:0] granted_dest_port_all,
    input  logic [P*Fw-1:0]  flit_in_all,
    input  logic [P-1:0]     flit_in_wr_all,
    output logic [P*Fw-1:0]  flit_out_all,
    output logic [P-1:0]     flit_out_wr_all,
    output logic [P-1:0]     lock_busy_all,
    output logic [P-1:0]     conflict_err_all
`ifdef CROSSBAR_PIPE_STAT_EN
    ,
    output logic [P*32-1:0]  stat_flit_cnt_all,
    output logic [P*32-1:0]  stat_pkt_cnt_all
`endif
);

    // req[o][i]: input i holds a valid flit granted to output o
    logic [P-1:0] req [P];

    always_comb begin
        for (int o = 0; o < P; o++) begin
            req[o] = '0;
            for (int i = 0; i < P; i++)
                if (SELF_LOOP_EN != 0 || o != i)
                    req[o][i] = flit_in_wr_all[i] &
                                granted_dest_port_all[i*P_1 + grant_idx(o, i, SELF_LOOP_EN != 0)];
        end
    end

    for (genvar o = 0; o < P; o++) begin : g_out
        crossbar_out_port #(
            .P       (P),
            .Fw      (Fw),
            .OUT_REG (OUT_REG)
        ) u_port (
            .clk          (clk),
            .reset        (reset),
            .req          (req[o]),
            .flit_in_all  (flit_in_all),
            .flit_out     (flit_out_all[o*Fw +: Fw]),
            .flit_out_wr  (flit_out_wr_all[o]),
            .lock_busy    (lock_busy_all[o]),
            .conflict_err (conflict_err_all[o])
`ifdef CROSSBAR_PIPE_STAT_EN
            ,
            .stat_flit_cnt (stat_flit_cnt_all[o*32 +: 32]),
            .stat_pkt_cnt  (stat_pkt_cnt_all[o*32 +: 32])
`endif
        );
    end

endmodule

// File: tb/tb_crossbar_pipe.sv
// Scoreboard bench for crossbar_pipe: registered and combinational instances
// driven with identical stimulus; stats checked when CROSSBAR_PIPE_STAT_EN is set.
module tb_crossbar_pipe;

    localparam int P  = 5;
    localparam int FW = 36;
    localparam int P1 = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [P*P1-1:0] gnt;
    logic [P*FW-1:0] fin;
    logic [P-1:0]    fwr;

    logic [P*FW-1:0] r_flit, c_flit;
    logic [P-1:0]    r_wr, c_wr, r_lock, c_lock, r_err, c_err;
`ifdef CROSSBAR_PIPE_STAT_EN
    logic [P*32-1:0] r_sflit, r_spkt, c_sflit, c_spkt;
`endif

    crossbar_pipe #(.NOC_ID(0), .P(P), .Fw(FW), .SELF_LOOP_EN(0), .OUT_REG(1)) dut_r (
        .clk (clk), .reset (reset),
        .granted_dest_port_all (gnt), .flit_in_all (fin), .flit_in_wr_all (fwr),
        .flit_out_all (r_flit), .flit_out_wr_all (r_wr),
        .lock_busy_all (r_lock), .conflict_err_all (r_err)
`ifdef CROSSBAR_PIPE_STAT_EN
        , .stat_flit_cnt_all (r_sflit), .stat_pkt_cnt_all (r_spkt)
`endif
    );

    crossbar_pipe #(.NOC_ID(0), .P(P), .Fw(FW), .SELF_LOOP_EN(0), .OUT_REG(0)) dut_c (
        .clk (clk), .reset (reset),
        .granted_dest_port_all (gnt), .flit_in_all (fin), .flit_in_wr_all (fwr),
        .flit_out_all (c_flit), .flit_out_wr_all (c_wr),
        .lock_busy_all (c_lock), .conflict_err_all (c_err)
`ifdef CROSSBAR_PIPE_STAT_EN
        , .stat_flit_cnt_all (c_sflit), .stat_pkt_cnt_all (c_spkt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          o;
        logic        wr;
        logic [35:0] flit;
        logic        lock;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [35:0] mk(input logic h, input logic t, input logic [33:0] p);
        return {h, t, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        gnt = '0;
        fin = '0;
        fwr = '0;
    endtask

    task automatic send(input int s, input int d, input logic [35:0] f);
        int idx;
        idx = (d > s) ? d - 1 : d;
        fwr[s]            = 1'b1;
        gnt[s*P1 +: P1]   = 4'b0001 << idx;
        fin[s*FW +: FW]   = f;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (r_flit !== '0 || r_wr !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got wr=%b flit=%h, want all zero", r_wr, r_flit);
        end
        n_cmp++;
        if (r_lock !== '0 || c_lock !== '0) begin
            n_fail++;
            $display("FAIL reset_lock: got r=%b c=%b, want 0", r_lock, c_lock);
        end
        n_cmp++;
        if (r_err !== '0 || c_err !== '0) begin
            n_fail++;
            $display("FAIL reset_err: got r=%b c=%b, want 0", r_err, c_err);
        end
        n_cmp++;
        if (c_flit !== '0 || c_wr !== '0) begin
            n_fail++;
            $display("FAIL reset_comb: got wr=%b flit=%h, want all zero", c_wr, c_flit);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            int k;
            k = 1 + (c % 4);
            clear_inputs();
            for (int i = 0; i < P; i++) begin
                logic [35:0] f;
                int          d;
                d = (i + k) % P;
                f = mk(1'b1, 1'b1, {2'($urandom), 32'($urandom)});
                send(i, d, f);
                sb.push_back('{o: d, wr: 1'b1, flit: f, lock: 1'b0});
            end
            #1;
            for (int j = 0; j < P; j++) begin
                e = sb[sb.size() - P + j];
                n_cmp++;
                if (c_wr[e.o] !== 1'b1 || c_flit[e.o*FW +: FW] !== e.flit) begin
                    n_fail++;
                    $display("FAIL b2b_comb c%0d o%0d: got wr=%b flit=%h, want wr=1 flit=%h",
                             c, e.o, c_wr[e.o], c_flit[e.o*FW +: FW], e.flit);
                end
            end
            step();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (r_wr[e.o] !== e.wr || r_flit[e.o*FW +: FW] !== e.flit || r_lock[e.o] !== e.lock) begin
                    n_fail++;
                    $display("FAIL b2b_reg c%0d o%0d: got wr=%b flit=%h lock=%b, want wr=%b flit=%h lock=%b",
                             c, e.o, r_wr[e.o], r_flit[e.o*FW +: FW], r_lock[e.o], e.wr, e.flit, e.lock);
                end
            end
        end
        clear_inputs();
        step();
        n_cmp++;
        if (r_err !== '0) begin
            n_fail++;
            $display("FAIL b2b_err: got %b, want 0", r_err);
        end
    endtask

    task automatic test_packet();
        logic [35:0] f[3];
        exp_t        e;
        f[0] = mk(1'b1, 1'b0, 34'h0_1111_0001);
        f[1] = mk(1'b0, 1'b0, 34'h2_2222_0002);
        f[2] = mk(1'b0, 1'b1, 34'h3_3333_0003);
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c < 3) begin
                send(1, 3, f[c]);
                sb.push_back('{o: 3, wr: 1'b1, flit: f[c], lock: (c < 2)});
            end else begin
                sb.push_back('{o: 3, wr: 1'b0, flit: f[2], lock: 1'b0});
            end
            #1;
            e = sb[$];
            n_cmp++;
            if (c_wr[3] !== e.wr || c_flit[3*FW +: FW] !== (e.wr ? e.flit : 36'h0)) begin
                n_fail++;
                $display("FAIL pkt_comb c%0d: got wr=%b flit=%h, want wr=%b flit=%h",
                         c, c_wr[3], c_flit[3*FW +: FW], e.wr, e.wr ? e.flit : 36'h0);
            end
            step();
            e = sb.pop_front();
            n_cmp++;
            if (r_wr[3] !== e.wr || r_flit[3*FW +: FW] !== e.flit || r_lock[3] !== e.lock) begin
                n_fail++;
                $display("FAIL pkt_reg c%0d: got wr=%b flit=%h lock=%b, want wr=%b flit=%h lock=%b",
                         c, r_wr[3], r_flit[3*FW +: FW], r_lock[3], e.wr, e.flit, e.lock);
            end
        end
        n_cmp++;
        if (r_err[3] !== 1'b0 || c_err[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_err: got r=%b c=%b, want 0", r_err[3], c_err[3]);
        end
    endtask

    task automatic test_conflict();
        logic [35:0] fa, fb;
        exp_t        e;
        fa = mk(1'b1, 1'b1, 34'h0_AAAA_000A);
        fb = mk(1'b1, 1'b1, 34'h1_BBBB_000B);
        clear_inputs();
        send(0, 4, fa);
        send(2, 4, fb);
        sb.push_back('{o: 4, wr: 1'b1, flit: fa, lock: 1'b0});
        #1;
        n_cmp++;
        if (c_flit[4*FW +: FW] !== fa) begin
            n_fail++;
            $display("FAIL conflict_comb: got flit=%h, want %h", c_flit[4*FW +: FW], fa);
        end
        step();
        e = sb.pop_front();
        n_cmp++;
        if (r_wr[4] !== e.wr || r_flit[4*FW +: FW] !== e.flit || r_lock[4] !== e.lock) begin
            n_fail++;
            $display("FAIL conflict_fwd: got wr=%b flit=%h lock=%b, want wr=%b flit=%h lock=%b",
                     r_wr[4], r_flit[4*FW +: FW], r_lock[4], e.wr, e.flit, e.lock);
        end
        n_cmp++;
        if (r_err[4] !== 1'b1 || c_err[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set: got r=%b c=%b, want 1", r_err[4], c_err[4]);
        end
        clear_inputs();
        step();
        step();
        n_cmp++;
        if (r_err !== 5'b10000) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b, want 10000", r_err);
        end
    endtask

    task automatic test_lock_drop();
        logic [35:0] f[3];
        logic [35:0] intr;
        exp_t        e;
        f[0] = mk(1'b1, 1'b0, 34'h0_C0C0_0100);
        f[1] = mk(1'b0, 1'b0, 34'h0_C0C0_0101);
        f[2] = mk(1'b0, 1'b1, 34'h0_C0C0_0102);
        intr = mk(1'b1, 1'b0, 34'h3_DEAD_0200);
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            send(1, 3, f[c]);
            if (c == 1)
                send(2, 3, intr);
            sb.push_back('{o: 3, wr: 1'b1, flit: f[c], lock: (c < 2)});
            step();
            e = sb.pop_front();
            n_cmp++;
            if (r_wr[3] !== e.wr || r_flit[3*FW +: FW] !== e.flit || r_lock[3] !== e.lock) begin
                n_fail++;
                $display("FAIL lockdrop c%0d: got wr=%b flit=%h lock=%b, want wr=%b flit=%h lock=%b",
                         c, r_wr[3], r_flit[3*FW +: FW], r_lock[3], e.wr, e.flit, e.lock);
            end
        end
        n_cmp++;
        if (r_err[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL lockdrop_err: got %b, want 1", r_err[3]);
        end
        clear_inputs();
    endtask

    task automatic test_tail_vs_header();
        logic [35:0] h1, t1, h0, t0;
        exp_t        e;
        h1 = mk(1'b1, 1'b0, 34'h1_1000_0001);
        t1 = mk(1'b0, 1'b1, 34'h1_1000_0002);
        h0 = mk(1'b1, 1'b0, 34'h2_0000_0003);
        t0 = mk(1'b0, 1'b1, 34'h2_0000_0004);
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin send(1, 3, h1); sb.push_back('{o: 3, wr: 1'b1, flit: h1, lock: 1'b1}); end
                1: begin send(1, 3, t1); send(0, 3, h0);
                         sb.push_back('{o: 3, wr: 1'b1, flit: t1, lock: 1'b0}); end
                2: begin send(0, 3, h0); sb.push_back('{o: 3, wr: 1'b1, flit: h0, lock: 1'b1}); end
                default: begin send(0, 3, t0); sb.push_back('{o: 3, wr: 1'b1, flit: t0, lock: 1'b0}); end
            endcase
            step();
            e = sb.pop_front();
            n_cmp++;
            if (r_wr[3] !== e.wr || r_flit[3*FW +: FW] !== e.flit || r_lock[3] !== e.lock) begin
                n_fail++;
                $display("FAIL tailhdr c%0d: got wr=%b flit=%h lock=%b, want wr=%b flit=%h lock=%b",
                         c, r_wr[3], r_flit[3*FW +: FW], r_lock[3], e.wr, e.flit, e.lock);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        logic [35:0] h, b;
        h = mk(1'b1, 1'b0, 34'h0_5555_0001);
        b = mk(1'b0, 1'b0, 34'h0_5555_0002);
        clear_inputs();
        send(1, 3, h);
        step();
        n_cmp++;
        if (r_lock[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_lock: got %b, want 1", r_lock[3]);
        end
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (r_flit !== '0 || r_wr !== '0 || r_lock !== '0 || r_err !== '0 || c_lock !== '0) begin
            n_fail++;
            $display("FAIL rstmid_zero: got wr=%b lock=%b err=%b flit=%h, want all zero",
                     r_wr, r_lock, r_err, r_flit);
        end
        send(1, 3, b);
        #1;
        n_cmp++;
        if (c_wr[3] !== 1'b1 || c_flit[3*FW +: FW] !== b) begin
            n_fail++;
            $display("FAIL rstmid_comb: got wr=%b flit=%h, want wr=1 flit=%h", c_wr[3], c_flit[3*FW +: FW], b);
        end
        step();
        n_cmp++;
        if (r_wr[3] !== 1'b1 || r_flit[3*FW +: FW] !== b || r_lock[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_body: got wr=%b flit=%h lock=%b, want wr=1 flit=%h lock=0",
                     r_wr[3], r_flit[3*FW +: FW], r_lock[3], b);
        end
        clear_inputs();
    endtask

`ifdef CROSSBAR_PIPE_STAT_EN
    task automatic test_stats();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int pk = 0; pk < 10; pk++)
            for (int fl = 0; fl < 4; fl++) begin
                clear_inputs();
                send(0, 2, mk(fl == 0, fl == 3, 34'(pk * 16 + fl)));
                step();
            end
        clear_inputs();
        step();
        n_cmp++;
        if (r_sflit[2*32 +: 32] !== 32'd40 || c_sflit[2*32 +: 32] !== 32'd40) begin
            n_fail++;
            $display("FAIL stat_flit: got r=%0d c=%0d, want 40", r_sflit[2*32 +: 32], c_sflit[2*32 +: 32]);
        end
        n_cmp++;
        if (r_spkt[2*32 +: 32] !== 32'd10 || c_spkt[2*32 +: 32] !== 32'd10) begin
            n_fail++;
            $display("FAIL stat_pkt: got r=%0d c=%0d, want 10", r_spkt[2*32 +: 32], c_spkt[2*32 +: 32]);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_packet();
        test_conflict();
        test_lock_drop();
        test_tail_vs_header();
        test_reset_mid_packet();
`ifdef CROSSBAR_PIPE_STAT_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/crossbar_pipe.md
CROSSBAR_PIPE -- requirements
Module: crossbar_pipe

Interface
REQ-001 SHALL have parameter NOC_ID, default 0: NoC instance identifier.
REQ-002 SHALL have parameter P, default 5: router port count, 2..16.
REQ-003 SHALL have parameter Fw, default 36: flit width, >=4; bit Fw-1 = header, bit Fw-2 = tail.
REQ-004 SHALL have parameter SELF_LOOP_EN, default 0: 1 = input i may drive output i; P_1 = SELF_LOOP_EN ? P : P-1.
REQ-005 SHALL have parameter OUT_REG, default 1: 1 = registered outputs, 0 = combinational outputs.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-008 SHALL have port granted_dest_port_all, input, P*P_1: per-input one-hot output grant, in compressed form when SELF_LOOP_EN=0.
REQ-009 SHALL have port flit_in_all, input, P*Fw: input flits.
REQ-010 SHALL have port flit_in_wr_all, input, P: per-input flit valid.
REQ-011 SHALL have port flit_out_all, output, P*Fw: output flits.
REQ-012 SHALL have port flit_out_wr_all, output, P: per-output flit valid.
REQ-013 SHALL have port lock_busy_all, output, P: output currently locked to a packet.
REQ-014 SHALL have port conflict_err_all, output, P: sticky per-output conflict flag.

Function
REQ-015 Requesters of output o SHALL be the inputs j with flit_in_wr[j]=1 and an expanded grant bit for o.
REQ-016 Each output SHALL run a 2-state FSM: IDLE and LOCKED(src), where src is a one-hot input register.
REQ-017 In IDLE with one or more requesters, the output SHALL forward the lowest-index requester.
REQ-018 In IDLE, a forwarded header flit with tail=0 SHALL move the FSM to LOCKED with src = that input.
REQ-019 In IDLE, a single-flit packet (header=1, tail=1) SHALL leave the FSM in IDLE.
REQ-020 In LOCKED, the output SHALL forward only src, and only when src has both wr and grant asserted; no other input is forwarded.
REQ-021 In LOCKED, a forwarded flit with tail=1 SHALL return the FSM to IDLE in the next cycle.
REQ-022 If a tail and a new requester occur in the same cycle, the tail SHALL win; the new requester is served at the earliest one cycle later.
REQ-023 conflict_err[o] SHALL set when two or more requesters exist in one cycle, or when a non-src requester exists while LOCKED; it stays set until reset.
REQ-024 With OUT_REG=1, flit_out and flit_out_wr SHALL appear 1 cycle after the input.
REQ-025 With OUT_REG=1, flit_out SHALL hold its last value when wr=0.
REQ-026 With OUT_REG=0, the outputs SHALL be valid in the same cycle, and flit_out SHALL be 0 when wr=0.
REQ-027 lock_busy[o] SHALL equal (state==LOCKED) and SHALL be registered in both modes.
REQ-028 A header arriving while LOCKED from src SHALL be forwarded as data; the lock remains held.

Reset
REQ-029 On reset, all FSMs SHALL go to IDLE, src=0, and flit_out_all, flit_out_wr_all, lock_busy_all and conflict_err_all SHALL be 0.
REQ-030 Reset mid-packet SHALL abandon the lock; the next flit is treated from IDLE (a non-header flit passes without locking).

Configuration
REQ-031 The macro CROSSBAR_PIPE_STAT_EN SHALL control per-output statistics.
REQ-032 When defined, the block SHALL add output port stat_flit_cnt_all, P*32: per-output count of forwarded flits, saturating at 32'hFFFFFFFF, cleared by reset.
REQ-033 When defined, the block SHALL add output port stat_pkt_cnt_all, P*32: count of forwarded tail flits, with the same saturation and reset.
REQ-034 When undefined, these ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Header/tail bit positions and a grant-expansion helper (compressed P_1 to P one-hot) SHALL live in pronoc_def.v and a shared package.
REQ-036 Per-output logic (request mask, lowest-index select, FSM, mux, output register, counters) SHALL be one sub-module, crossbar_out_port, instantiated P times.

Verification
REQ-037 P=5, Fw=36, OUT_REG=1: input 1 sends a 3-flit packet (H, B, T) to output 3 -> out3 wr=1 on cycles 1-3 with identical flits; lock_busy[3]=1 after H until the cycle after T; err=0.
REQ-038 In the same cycle inputs 0 and 2 both send single-flit packets to output 4 -> input 0 is forwarded and conflict_err[4]=1 and stays 1 until reset.
REQ-039 Input 1 locked to output 3 and input 2 sends a header to output 3 -> input 2 is dropped, conflict_err[3]=1, and input 1's body/tail are still forwarded.
REQ-040 Tail from input 1 and a header from input 0 both at output 3 in cycle t -> the tail is forwarded at t; input 0's header is forwarded at t+1 or later.
REQ-041 Reset asserted for 1 cycle mid-packet -> all outputs 0 the next cycle and lock_busy=0; a following body flit passes without locking.
REQ-042 CROSSBAR_PIPE_STAT_EN defined, 10 packets of 4 flits to output 2 -> stat_flit_cnt[2]=40 and stat_pkt_cnt[2]=10; OUT_REG=0 run shows zero latency.
